// File: rtl/branch_resolution_unit.sv
// Two-wide branch resolution: tracks in-flight predictions in an in-order queue,
// trains the predictor on resolution and runs a two-cycle flush on a mispredict.
module branch_resolution_unit #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fb1,
  input  logic              fb2,
  input  logic              fpred1,
  input  logic              fpred2,
  input  logic [DATA_W-1:0] fpc1,
  input  logic [DATA_W-1:0] fpc2,
  input  logic              fstall,
  input  logic              eb1,
  input  logic              eb2,
  input  logic              etaken1,
  input  logic              etaken2,
  input  logic [DATA_W-1:0] epc1,
  input  logic [DATA_W-1:0] epc2,
  input  logic [DATA_W-1:0] etgt1,
  input  logic [DATA_W-1:0] etgt2,
  output logic              upd_br1,
  output logic              upd_br2,
  output logic              upd_taken1,
  output logic              upd_taken2,
  output logic [DATA_W-1:0] upd_pc1,
  output logic [DATA_W-1:0] upd_pc2,
  output logic              flush,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              q_full,
  output logic              ovf_err,
  output logic              unf_err,
  output logic [15:0]       br_count,
  output logic [15:0]       mp_count
);

  typedef enum logic [1:0] {IDLE, FLUSH1, FLUSH2} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] q_pc   [8];
  logic              q_pred [8];
  logic [2:0]        head, tail;
  logic [3:0]        count;

  logic              idle, fetch_ok;
  logic [3:0]        free;
  logic              push1, push2, drop;
  logic              res1, res2, avail1, avail2, pop1, pop2;
  logic              pred1, pred2, mp1, mp2, mispredict, underflow;
  logic [2:0]        idx2;
  logic [1:0]        npush, npop, nres;
  logic [DATA_W-1:0] tgt;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [DATA_W-1:0] mp_target(input logic taken,
                                                  input logic [DATA_W-1:0] pc,
                                                  input logic [DATA_W-1:0] tg);
    return taken ? tg : pc + 1'b1;
  endfunction

  always_comb begin
    idle     = (state == IDLE);
    fetch_ok = idle && !fstall;
    free     = 4'd8 - count;
    push1    = fetch_ok && fb1 && (free != 4'd0);
    push2    = fetch_ok && fb2 && (push1 ? (free >= 4'd2) : (free != 4'd0));
    drop     = fetch_ok && ((fb1 && !push1) || (fb2 && !push2));

    // Resolution only sees entries present at the start of the cycle
    res1     = idle && eb1;
    avail1   = (count != 4'd0);
    pop1     = res1 && avail1;
    pred1    = avail1 ? q_pred[head] : 1'b0;
    mp1      = res1 && (pred1 != etaken1);

    res2     = idle && eb2 && !mp1;
    idx2     = eb1 ? head + 3'd1 : head;
    avail2   = eb1 ? (count >= 4'd2) : (count != 4'd0);
    pop2     = res2 && avail2;
    pred2    = avail2 ? q_pred[idx2] : 1'b0;
    mp2      = res2 && (pred2 != etaken2);

    mispredict = mp1 || mp2;
    underflow  = (res1 && !avail1) || (res2 && !avail2);
    tgt        = mp1 ? mp_target(etaken1, epc1, etgt1) : mp_target(etaken2, epc2, etgt2);

    npush = {1'b0, push1} + {1'b0, push2};
    npop  = {1'b0, pop1} + {1'b0, pop2};
    nres  = {1'b0, res1} + {1'b0, res2};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mispredict) state_nxt = FLUSH1;
      FLUSH1:  state_nxt = FLUSH2;
      FLUSH2:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Queue pointers; a mispredict drops everything still in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= 3'd0;
      tail  <= 3'd0;
      count <= 4'd0;
    end else if (mispredict) begin
      head  <= 3'd0;
      tail  <= 3'd0;
      count <= 4'd0;
    end else begin
      head  <= head + {1'b0, npop};
      tail  <= tail + {1'b0, npush};
      count <= count + {2'd0, npush} - {2'd0, npop};
    end
  end

  always_ff @(posedge clk) begin
    if (push1) begin
      q_pc[tail]   <= fpc1;
      q_pred[tail] <= fpred1;
    end
    if (push2) begin
      q_pc[tail + {2'd0, push1}]   <= fpc2;
      q_pred[tail + {2'd0, push1}] <= fpred2;
    end
  end

  // Training stage, counters, sticky errors and redirect address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_br1     <= 1'b0;
      upd_br2     <= 1'b0;
      upd_taken1  <= 1'b0;
      upd_taken2  <= 1'b0;
      upd_pc1     <= '0;
      upd_pc2     <= '0;
      redirect_pc <= '0;
      ovf_err     <= 1'b0;
      unf_err     <= 1'b0;
      br_count    <= 16'd0;
      mp_count    <= 16'd0;
    end else begin
      upd_br1    <= res1;
      upd_br2    <= res2;
      upd_taken1 <= res1 ? etaken1 : 1'b0;
      upd_taken2 <= res2 ? etaken2 : 1'b0;
      upd_pc1    <= res1 ? epc1 : '0;
      upd_pc2    <= res2 ? epc2 : '0;
      if (mispredict) redirect_pc <= tgt;
      if (drop)       ovf_err <= 1'b1;
      if (underflow)  unf_err <= 1'b1;
      br_count <= sat_add16(br_count, nres);
      mp_count <= sat_add16(mp_count, {1'b0, mispredict});
    end
  end

  assign flush  = (state != IDLE);
  assign q_full = (count >= 4'd7);

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with hand-computed expectations.
module tb_branch_resolution_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       fb1, fb2, fpred1, fpred2, fstall;
  logic [7:0] fpc1, fpc2;
  logic       eb1, eb2, etaken1, etaken2;
  logic [7:0] epc1, epc2, etgt1, etgt2;
  logic       upd_br1, upd_br2, upd_taken1, upd_taken2;
  logic [7:0] upd_pc1, upd_pc2, redirect_pc;
  logic       flush, q_full, ovf_err, unf_err;
  logic [15:0] br_count, mp_count;

  int checks = 0;
  int failures = 0;

  branch_resolution_unit dut (
    .clk(clk), .reset(reset),
    .fb1(fb1), .fb2(fb2), .fpred1(fpred1), .fpred2(fpred2),
    .fpc1(fpc1), .fpc2(fpc2), .fstall(fstall),
    .eb1(eb1), .eb2(eb2), .etaken1(etaken1), .etaken2(etaken2),
    .epc1(epc1), .epc2(epc2), .etgt1(etgt1), .etgt2(etgt2),
    .upd_br1(upd_br1), .upd_br2(upd_br2),
    .upd_taken1(upd_taken1), .upd_taken2(upd_taken2),
    .upd_pc1(upd_pc1), .upd_pc2(upd_pc2),
    .flush(flush), .redirect_pc(redirect_pc), .q_full(q_full),
    .ovf_err(ovf_err), .unf_err(unf_err),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fb1 = 0; fb2 = 0; fpred1 = 0; fpred2 = 0; fpc1 = 0; fpc2 = 0; fstall = 0;
    eb1 = 0; eb2 = 0; etaken1 = 0; etaken2 = 0;
    epc1 = 0; epc2 = 0; etgt1 = 0; etgt2 = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_flush"}, {15'd0, flush}, 16'd0);
    chk({tag, "_redir"}, {8'd0, redirect_pc}, 16'd0);
    chk({tag, "_upd1"}, {6'd0, upd_br1, upd_taken1, upd_pc1}, 16'd0);
    chk({tag, "_upd2"}, {6'd0, upd_br2, upd_taken2, upd_pc2}, 16'd0);
    chk({tag, "_errs"}, {14'd0, ovf_err, unf_err}, 16'd0);
    chk({tag, "_qfull"}, {15'd0, q_full}, 16'd0);
    chk({tag, "_br"}, br_count, 16'd0);
    chk({tag, "_mp"}, mp_count, 16'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #1 reset = 0;
    #1 chk_reset_values("rst");
    step();
    step();
    reset = 1;

    // Correct prediction
    fb1 = 1; fpc1 = 8'h10; fpred1 = 1;
    step();
    idle_inputs();
    eb1 = 1; etaken1 = 1; epc1 = 8'h10; etgt1 = 8'h55;
    step();
    idle_inputs();
    chk("ok_flush", {15'd0, flush}, 16'd0);
    chk("ok_upd1", {6'd0, upd_br1, upd_taken1, upd_pc1}, {6'd0, 2'b11, 8'h10});
    chk("ok_upd2", {15'd0, upd_br2}, 16'd0);
    chk("ok_br", br_count, 16'd1);
    chk("ok_mp", mp_count, 16'd0);
    step();
    chk("ok_pulse", {15'd0, upd_br1}, 16'd0);

    // Not-taken mispredict at 8'hFF wraps to 8'h00
    fb1 = 1; fpc1 = 8'hFF; fpred1 = 1;
    step();
    idle_inputs();
    eb1 = 1; etaken1 = 0; epc1 = 8'hFF; etgt1 = 8'h77;
    step();
    idle_inputs();
    chk("wrap_f1", {15'd0, flush}, 16'd1);
    chk("wrap_redir", {8'd0, redirect_pc}, 16'h0000);
    chk("wrap_upd1", {6'd0, upd_br1, upd_taken1, upd_pc1}, {6'd0, 2'b10, 8'hFF});
    chk("wrap_mp", mp_count, 16'd1);
    chk("wrap_br", br_count, 16'd2);
    step();
    chk("wrap_f2", {15'd0, flush}, 16'd1);
    chk("wrap_redir2", {8'd0, redirect_pc}, 16'h0000);
    step();
    chk("wrap_f3", {15'd0, flush}, 16'd0);

    // Dual resolve with slot-1 mispredict: slot 2 ignored
    fb1 = 1; fpc1 = 8'h20; fpred1 = 0;
    fb2 = 1; fpc2 = 8'h21; fpred2 = 1;
    step();
    idle_inputs();
    eb1 = 1; etaken1 = 1; epc1 = 8'h20; etgt1 = 8'h40;
    eb2 = 1; etaken2 = 1; epc2 = 8'h21; etgt2 = 8'h99;
    step();
    idle_inputs();
    chk("dual_flush", {15'd0, flush}, 16'd1);
    chk("dual_redir", {8'd0, redirect_pc}, 16'h0040);
    chk("dual_upd1", {6'd0, upd_br1, upd_taken1, upd_pc1}, {6'd0, 2'b11, 8'h20});
    chk("dual_upd2", {15'd0, upd_br2}, 16'd0);
    chk("dual_br", br_count, 16'd3);
    chk("dual_mp", mp_count, 16'd2);
    step();
    step();

    // Dual resolve with slot-2 mispredict: both slots train
    fb1 = 1; fpc1 = 8'h30; fpred1 = 1;
    fb2 = 1; fpc2 = 8'h31; fpred2 = 0;
    step();
    idle_inputs();
    eb1 = 1; etaken1 = 1; epc1 = 8'h30; etgt1 = 8'hAA;
    eb2 = 1; etaken2 = 1; epc2 = 8'h31; etgt2 = 8'h50;
    step();
    idle_inputs();
    chk("s2_flush", {15'd0, flush}, 16'd1);
    chk("s2_redir", {8'd0, redirect_pc}, 16'h0050);
    chk("s2_upd1", {6'd0, upd_br1, upd_taken1, upd_pc1}, {6'd0, 2'b11, 8'h30});
    chk("s2_upd2", {6'd0, upd_br2, upd_taken2, upd_pc2}, {6'd0, 2'b11, 8'h31});
    chk("s2_br", br_count, 16'd5);
    chk("s2_mp", mp_count, 16'd3);
    step();
    step();
    chk("s2_idle", {15'd0, flush}, 16'd0);

    // Overflow: four double pushes fill the queue, the fifth is dropped
    for (int k = 0; k < 4; k++) begin
      fb1 = 1; fb2 = 1; fpred1 = 0; fpred2 = 0;
      fpc1 = 8'h80 + 8'(2 * k); fpc2 = 8'h81 + 8'(2 * k);
      step();
      if (k == 2) chk("ovf_qfull6", {15'd0, q_full}, 16'd0);
    end
    chk("ovf_qfull8", {15'd0, q_full}, 16'd1);
    chk("ovf_pre", {15'd0, ovf_err}, 16'd0);
    step();
    idle_inputs();
    chk("ovf_err", {15'd0, ovf_err}, 16'd1);
    eb1 = 1; etaken1 = 1; epc1 = 8'h80; etgt1 = 8'h60;
    step();
    idle_inputs();
    chk("ovf_flush", {15'd0, flush}, 16'd1);
    chk("ovf_empty", {15'd0, q_full}, 16'd0);
    chk("ovf_redir", {8'd0, redirect_pc}, 16'h0060);
    step();
    step();

    // Underflow, then fetch ignored during flush
    eb1 = 1; etaken1 = 1; epc1 = 8'h01; etgt1 = 8'h33;
    step();
    idle_inputs();
    chk("unf_err", {15'd0, unf_err}, 16'd1);
    chk("unf_flush", {15'd0, flush}, 16'd1);
    chk("unf_redir", {8'd0, redirect_pc}, 16'h0033);
    chk("unf_mp", mp_count, 16'd5);
    fb1 = 1; fpred1 = 1; fpc1 = 8'h44;
    step();
    idle_inputs();
    step();
    chk("ign_idle", {15'd0, flush}, 16'd0);
    // An empty queue resolves with pred=0, so not-taken must not mispredict
    eb1 = 1; etaken1 = 0; epc1 = 8'h05;
    step();
    idle_inputs();
    chk("ign_noflush", {15'd0, flush}, 16'd0);
    chk("ign_br", br_count, 16'd8);
    chk("ign_mp", mp_count, 16'd5);

    // Reset in the middle of a flush
    fb1 = 1; fpc1 = 8'h70; fpred1 = 0;
    step();
    idle_inputs();
    eb1 = 1; etaken1 = 1; epc1 = 8'h70; etgt1 = 8'h90;
    step();
    idle_inputs();
    chk("mid_flush", {15'd0, flush}, 16'd1);
    reset = 0;
    #1 chk_reset_values("midrst");
    step();
    reset = 1;
    step();
    chk("post_rst_idle", {15'd0, flush}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolution_unit.md
BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- fb1, fb2  in  1  fetch slot 1/2 holds a branch (slot 1 older)
- fpred1, fpred2  in  1  prediction issued for fetch slot 1/2 (1 = taken)
- fpc1, fpc2  in  8  PC of fetch slot 1/2
- fstall  in  1  fetch stalled; no push this cycle
- eb1, eb2  in  1  execute slot 1/2 resolves a branch (slot 1 older)
- etaken1, etaken2  in  1  actual outcome of execute slot 1/2
- epc1, epc2  in  8  PC of execute slot 1/2
- etgt1, etgt2  in  8  branch target of execute slot 1/2
- upd_br1, upd_br2  out  1  predictor-table update strobe, slot 1/2
- upd_taken1, upd_taken2  out  1  outcome to train with
- upd_pc1, upd_pc2  out  8  PC whose counter is trained
- flush  out  1  squash all younger instructions
- redirect_pc  out  8  fetch restart address, valid while flush=1
- q_full  out  1  fewer than 2 free queue entries
- ovf_err, unf_err  out  1  sticky: push dropped / resolve with empty queue
- br_count, mp_count  out  16  resolved branches / mispredictions

Function
REQ-002 The block SHALL keep an 8-entry in-order queue of {pc[7:0], pred} for in-flight predicted branches, with 3-bit head/tail pointers wrapping 7->0 and a 4-bit occupancy count.
REQ-003 Push: when fstall=0 and state=IDLE, slot 1 SHALL be pushed if fb1=1, then slot 2 if fb2=1; both in one cycle allowed.
REQ-004 A push with no free entry SHALL be dropped and set ovf_err; an accepted slot 1 with a dropped slot 2 is legal.
REQ-005 q_full SHALL be combinational, 1 when occupancy >= 7.
REQ-006 Resolve: in IDLE, eb1=1 SHALL pop the head and compare its pred with etaken1; eb2=1 SHALL pop the next entry likewise, unless slot 1 mispredicted.
REQ-007 A resolve with no entry available SHALL use pred=0 and set unf_err.
REQ-008 Push and pop in the same cycle SHALL both take effect; a pop may consume an entry pushed in an earlier cycle but never one pushed the same cycle.
REQ-009 Mispredict target: etaken=1 -> etgt; etaken=0 -> epc+1, modulo 256 (8'hFF+1 = 8'h00).
REQ-010 Slot 1 mispredict SHALL take priority; slot 2 is then ignored (not popped, not counted, no update).
REQ-011 FSM states IDLE, FLUSH1, FLUSH2: IDLE->FLUSH1 on any mispredict; FLUSH1->FLUSH2; FLUSH2->IDLE unconditionally.
REQ-012 flush SHALL be 1 in FLUSH1 and FLUSH2 only. redirect_pc SHALL be registered on the mispredict edge and held through both cycles.
REQ-013 Entering FLUSH1 SHALL empty the queue (head=tail, count=0). In FLUSH1/FLUSH2, fetch and execute inputs SHALL be ignored.
REQ-014 upd_br/upd_taken/upd_pc SHALL be registered one cycle after each resolved slot, upd_br pulsing 1 cycle, values = etaken/epc of that slot.
REQ-015 br_count SHALL add the number of resolved slots (0-2) per cycle; mp_count SHALL add 1 per mispredict; both saturate at 16'hFFFF.
REQ-016 ovf_err and unf_err SHALL clear only on reset.

Reset
REQ-017 reset=0 SHALL asynchronously force: state=IDLE, queue empty, pointers 0, flush=0, redirect_pc=8'h00, all upd_* =0, ovf_err=unf_err=0, counters 0. q_full follows occupancy, so it reads 0.
REQ-018 Reset asserted mid-FLUSH SHALL abort the flush immediately. The first cycle after release SHALL be IDLE.

Verification
REQ-019 Correct predict: push fb1=1 fpc1=8'h10 fpred1=1; later eb1=1 etaken1=1 epc1=8'h10 -> flush stays 0; next cycle upd_br1=1 upd_taken1=1 upd_pc1=8'h10; br_count=1, mp_count=0.
REQ-020 Not-taken mispredict with wrap: queued pred=1 at 8'hFF; eb1=1 etaken1=0 epc1=8'hFF -> flush=1 for exactly 2 cycles, redirect_pc=8'h00, queue empty, mp_count=1.
REQ-021 Dual resolve, slot 1 mispredicts: queue {8'h20 pred0, 8'h21 pred1}; eb1=eb2=1, etaken1=1 etgt1=8'h40 -> redirect_pc=8'h40, only upd_br1 pulses, br_count +1.
REQ-022 Overflow: push 2 per cycle with no pops for 4 cycles -> q_full=1 after cycle 4 (count 8); a further push is dropped and sets ovf_err=1.
REQ-023 Underflow and flush ignore: eb1=1 with empty queue, etaken1=1, etgt1=8'h33 -> unf_err=1, mispredict, redirect_pc=8'h33; fb1=1 during FLUSH1 -> queue still empty after FLUSH2.
REQ-024 Reset mid-flush: assert reset=0 during FLUSH1 -> flush=0 at once and all outputs at REQ-017 values.
